// File: rtl/mem_arbiter_if.sv
// Bundle of every cache-side and memory-side signal of the shared memory port.
// The slave modport is the arbiter's view. The master modport is the view of the
// environment, i.e. the icache/dcache miss logic plus the main-memory model.
interface mem_arbiter_if #(
  parameter int LINE_BITS = 128
);
  // icache refill channel
  logic                 ic_req;
  logic [31:0]          ic_addr;
  logic                 ic_ready;
  logic [LINE_BITS-1:0] ic_rdata;

  // dcache refill / write-back channel
  logic                 dc_req;
  logic                 dc_we;
  logic [31:0]          dc_addr;
  logic [LINE_BITS-1:0] dc_wdata;
  logic                 dc_ready;
  logic [LINE_BITS-1:0] dc_rdata;

  // main-memory command port
  logic                 mem_en;
  logic                 mem_we;
  logic [31:0]          mem_addr;
  logic [LINE_BITS-1:0] mem_wdata;
  logic [LINE_BITS-1:0] mem_rdata;

  // status
  logic                 busy;
  logic                 grant_dc;

  // Caches and the memory model drive requests and read data, and observe the rest.
  modport master (
    output ic_req, ic_addr,
    output dc_req, dc_we, dc_addr, dc_wdata,
    output mem_rdata,
    input  ic_ready, ic_rdata, dc_ready, dc_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, grant_dc
  );

  // The arbiter samples requests and read data, and drives commands and responses.
  modport slave (
    input  ic_req, ic_addr,
    input  dc_req, dc_we, dc_addr, dc_wdata,
    input  mem_rdata,
    output ic_ready, ic_rdata, dc_ready, dc_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, grant_dc
  );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: sequences the one main-memory port between icache refills and dcache refill/write-back.
// Latency: request sampled at edge 0, mem_en in cycle 1, ready pulse in cycle MEM_LATENCY+2.
// Backpressure: level requests are held until ready. New requests are ignored while busy.
// Optional build macro ROUND_ROBIN_EN: ties alternate between caches instead of fixed dcache priority.
module mem_arbiter #(
  parameter int MEM_LATENCY = 5,
  parameter int LINE_BITS   = 128,
  parameter int LINE_BYTES  = 16
) (
  input  logic        clock,
  input  logic        reset,
  mem_arbiter_if.slave bus
);

  // Clearing the offset bits gives the line-aligned address presented to memory.
  localparam logic [31:0] ADDR_MASK = ~(32'(LINE_BYTES) - 32'd1);
  // WAIT lasts MEM_LATENCY cycles, so the counter counts MEM_LATENCY-1 down to 0.
  localparam logic [7:0]  CNT_LOAD  = 8'(MEM_LATENCY - 1);

  // Elaboration-time sanity checks on the parameters.
  if (MEM_LATENCY < 1 || MEM_LATENCY > 255) begin : g_bad_latency
    $error("mem_arbiter: MEM_LATENCY must be in 1..255");
  end
  if (LINE_BYTES < 1 || (LINE_BYTES & (LINE_BYTES - 1)) != 0) begin : g_bad_line_bytes
    $error("mem_arbiter: LINE_BYTES must be a power of 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t               r_state;
  logic [7:0]           r_cnt;
  logic                 r_grant_dc;
  logic                 r_mem_en;
  logic                 r_mem_we;
  logic [31:0]          r_mem_addr;
  logic [LINE_BITS-1:0] r_mem_wdata;
  logic                 r_ic_ready;
  logic                 r_dc_ready;
  logic [LINE_BITS-1:0] r_ic_rdata;
  logic [LINE_BITS-1:0] r_dc_rdata;
  logic                 r_busy;

  logic                 w_any_req;
  logic                 w_grant_dc;

  assign w_any_req = bus.ic_req | bus.dc_req;

`ifdef ROUND_ROBIN_EN
  // On a tie the cache that did not win last time is granted. A lone requester always wins.
  assign w_grant_dc = bus.dc_req & (~bus.ic_req | ~r_grant_dc);
`else
  // The data miss is older in the pipeline, so the dcache always wins a tie.
  assign w_grant_dc = bus.dc_req;
`endif

  // Access sequencer: grant, issue one command, count latency, return one ready pulse.
  // The mem_* registers double as the latched request, so they stay stable from ISSUE to RESP.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_grant_dc  <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= '0;
      r_ic_ready  <= 1'b0;
      r_dc_ready  <= 1'b0;
      r_ic_rdata  <= '0;
      r_dc_rdata  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant_dc  <= w_grant_dc;
            r_mem_addr  <= (w_grant_dc ? bus.dc_addr : bus.ic_addr) & ADDR_MASK;
            r_mem_we    <= w_grant_dc & bus.dc_we;
            r_mem_wdata <= w_grant_dc ? bus.dc_wdata : '0;
            r_mem_en    <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          r_mem_en <= 1'b0;
          r_cnt    <= CNT_LOAD;
          r_state  <= S_WAIT;
        end

        S_WAIT: begin
          if (r_cnt == 8'd0) begin
            // Memory data is valid only in this last WAIT cycle. Write-backs leave dc_rdata alone.
            if (r_grant_dc) begin
              if (!r_mem_we) begin
                r_dc_rdata <= bus.mem_rdata;
              end
              r_dc_ready <= 1'b1;
            end else begin
              r_ic_rdata <= bus.mem_rdata;
              r_ic_ready <= 1'b1;
            end
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end

        S_RESP: begin
          r_ic_ready <= 1'b0;
          r_dc_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.ic_ready  = r_ic_ready;
  assign bus.ic_rdata  = r_ic_rdata;
  assign bus.dc_ready  = r_dc_ready;
  assign bus.dc_rdata  = r_dc_rdata;
  assign bus.busy      = r_busy;
  assign bus.grant_dc  = r_grant_dc;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed accesses push expected commands/responses into
// per-instance queues; negedge monitors pop and compare whenever mem_en or a ready fires.
// A second instance runs with MEM_LATENCY=1. Tie expectations follow ROUND_ROBIN_EN.
module tb_mem_arbiter;
  localparam int LAT  = 5;
  localparam int LAT1 = 1;
  localparam int LB   = 128;
  localparam logic [LB-1:0] JUNK = {4{32'hDEAD_BEEF}};

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mem_arbiter_if #(.LINE_BITS(LB)) mif ();
  mem_arbiter_if #(.LINE_BITS(LB)) mif1 ();

  mem_arbiter #(.MEM_LATENCY(LAT), .LINE_BITS(LB), .LINE_BYTES(16)) dut (
    .clock(clock), .reset(reset), .bus(mif.slave)
  );
  mem_arbiter #(.MEM_LATENCY(LAT1), .LINE_BITS(LB), .LINE_BYTES(16)) dut1 (
    .clock(clock), .reset(reset), .bus(mif1.slave)
  );

  typedef struct {
    int           kind;   // 0 = mem command, 1 = icache ready, 2 = dcache ready
    int           cyc;
    logic [31:0]  addr;
    logic         we;
    logic [LB-1:0] wdata;
    logic         chk_wd;
    logic [LB-1:0] rdata;
    logic         gdc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;
  logic [LB-1:0] exp_ic0 = '0;
  logic [LB-1:0] exp_dc0 = '0;

  // Memory content model: a recognisable line per address.
  function automatic logic [LB-1:0] line_of(input logic [31:0] a);
    if (a == 32'h0000_1230) return {4{32'hA5A5_A5A5}};
    return {a ^ 32'hC3C3_3C3C, ~a, a, 32'h0BAD_F00D};
  endfunction

  // Memory models: read data is valid only in the last WAIT cycle, junk otherwise.
  int mc0 = 0;
  int mc1 = 0;
  always @(posedge clock) begin
    if (reset)           mc0 <= 0;
    else if (mif.mem_en) mc0 <= LAT;
    else if (mc0 > 0)    mc0 <= mc0 - 1;
  end
  always @(posedge clock) begin
    if (reset)            mc1 <= 0;
    else if (mif1.mem_en) mc1 <= LAT1;
    else if (mc1 > 0)     mc1 <= mc1 - 1;
  end
  assign mif.mem_rdata  = (mc0 == 1) ? line_of(mif.mem_addr)  : JUNK;
  assign mif1.mem_rdata = (mc1 == 1) ? line_of(mif1.mem_addr) : JUNK;

  task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cmp_evt(input string tag, input exp_t e, input int kind, input int c,
                         input logic [31:0] addr, input logic we, input logic [LB-1:0] wd,
                         input logic [LB-1:0] rd, input logic gdc, input logic bsy,
                         input logic both);
    chk({tag, "_kind"}, kind, e.kind);
    chk({tag, "_cycle"}, c, e.cyc);
    chk({tag, "_addr"}, addr, e.addr);
    chk({tag, "_we"}, we, e.we);
    if (e.chk_wd) chk({tag, "_wdata"}, wd, e.wdata);
    if (kind != 0) chk({tag, "_rdata"}, rd, e.rdata);
    chk({tag, "_grant_dc"}, gdc, e.gdc);
    chk({tag, "_busy"}, bsy, 1'b1);
    chk({tag, "_both_ready"}, both, 1'b0);
  endtask

  // Monitor for the default-latency instance.
  always @(negedge clock) begin
    if (mif.mem_en) begin
      if (q0.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL u0_cmd_unexpected: got mem_en at cycle %0d want none", cyc);
      end else begin
        m0 = q0.pop_front();
        cmp_evt("u0_cmd", m0, 0, cyc, mif.mem_addr, mif.mem_we, mif.mem_wdata, '0,
                mif.grant_dc, mif.busy, 1'b0);
      end
    end
    if (mif.ic_ready || mif.dc_ready) begin
      if (q0.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL u0_rsp_unexpected: got ready at cycle %0d want none", cyc);
      end else begin
        m0 = q0.pop_front();
        cmp_evt("u0_rsp", m0, mif.dc_ready ? 2 : 1, cyc, mif.mem_addr, mif.mem_we, mif.mem_wdata,
                mif.dc_ready ? mif.dc_rdata : mif.ic_rdata, mif.grant_dc, mif.busy,
                mif.ic_ready & mif.dc_ready);
      end
    end
  end

  // Monitor for the MEM_LATENCY=1 instance.
  always @(negedge clock) begin
    if (mif1.mem_en) begin
      if (q1.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL u1_cmd_unexpected: got mem_en at cycle %0d want none", cyc);
      end else begin
        m1 = q1.pop_front();
        cmp_evt("u1_cmd", m1, 0, cyc, mif1.mem_addr, mif1.mem_we, mif1.mem_wdata, '0,
                mif1.grant_dc, mif1.busy, 1'b0);
      end
    end
    if (mif1.ic_ready || mif1.dc_ready) begin
      if (q1.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL u1_rsp_unexpected: got ready at cycle %0d want none", cyc);
      end else begin
        m1 = q1.pop_front();
        cmp_evt("u1_rsp", m1, mif1.dc_ready ? 2 : 1, cyc, mif1.mem_addr, mif1.mem_we, mif1.mem_wdata,
                mif1.dc_ready ? mif1.dc_rdata : mif1.ic_rdata, mif1.grant_dc, mif1.busy,
                mif1.ic_ready & mif1.dc_ready);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Push the expected command (and optionally response) of one access on the default instance.
  task automatic expect_acc(input bit is_dc, input bit we, input logic [31:0] addr,
                            input logic [LB-1:0] wd, input int e0, input bit with_resp);
    exp_t c;
    exp_t r;
    logic [31:0] al;
    al       = addr & 32'hFFFF_FFF0;
    c.kind   = 0;
    c.cyc    = e0;
    c.addr   = al;
    c.we     = is_dc & we;
    c.wdata  = wd;
    c.chk_wd = is_dc;
    c.rdata  = '0;
    c.gdc    = is_dc;
    q0.push_back(c);
    if (with_resp) begin
      if (!is_dc)   exp_ic0 = line_of(al);
      else if (!we) exp_dc0 = line_of(al);
      r       = c;
      r.kind  = is_dc ? 2 : 1;
      r.cyc   = e0 + LAT + 1;
      r.rdata = is_dc ? exp_dc0 : exp_ic0;
      q0.push_back(r);
    end
  endtask

  // One complete access on the default instance; scramble changes dcache inputs mid-WAIT.
  task automatic run_acc(input bit is_dc, input bit we, input logic [31:0] addr,
                         input logic [LB-1:0] wd, input bit scramble);
    if (is_dc) begin
      mif.dc_req = 1'b1; mif.dc_we = we; mif.dc_addr = addr; mif.dc_wdata = wd;
    end else begin
      mif.ic_req = 1'b1; mif.ic_addr = addr;
    end
    expect_acc(is_dc, we, addr, wd, cyc + 1, 1'b1);
    for (int i = 0; i < LAT + 3; i++) begin
      tick();
      if (scramble && i == 3) begin
        mif.dc_wdata = JUNK; mif.dc_addr = 32'h7777_7770; mif.dc_we = 1'b0;
      end
    end
    if (is_dc) mif.dc_req = 1'b0;
    else       mif.ic_req = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_busy",      mif.busy,      1'b0);
    chk("rst_grant_dc",  mif.grant_dc,  1'b0);
    chk("rst_mem_en",    mif.mem_en,    1'b0);
    chk("rst_mem_we",    mif.mem_we,    1'b0);
    chk("rst_mem_addr",  mif.mem_addr,  32'd0);
    chk("rst_mem_wdata", mif.mem_wdata, '0);
    chk("rst_ic_ready",  mif.ic_ready,  1'b0);
    chk("rst_dc_ready",  mif.dc_ready,  1'b0);
    chk("rst_ic_rdata",  mif.ic_rdata,  '0);
    chk("rst_dc_rdata",  mif.dc_rdata,  '0);
    chk("rst1_busy",     mif1.busy,     1'b0);
    chk("rst1_dc_rdata", mif1.dc_rdata, '0);
  endtask

  initial begin
    reset = 1'b1;
    mif.ic_req  = 1'b0; mif.ic_addr  = '0;
    mif.dc_req  = 1'b0; mif.dc_we    = 1'b0; mif.dc_addr  = '0; mif.dc_wdata  = '0;
    mif1.ic_req = 1'b0; mif1.ic_addr = '0;
    mif1.dc_req = 1'b0; mif1.dc_we   = 1'b0; mif1.dc_addr = '0; mif1.dc_wdata = '0;
    tick();
    reset = 1'b0;
    chk_reset_state();

    // Single icache refill, dcache read, dcache write-back with inputs changed mid-WAIT.
    run_acc(1'b0, 1'b0, 32'h0000_1234, '0, 1'b0);
    run_acc(1'b1, 1'b0, 32'h0000_2008, {4{32'h55AA_55AA}}, 1'b0);
    run_acc(1'b1, 1'b1, 32'h8000_0040, {4{32'h1122_3344}}, 1'b1);
    run_acc(1'b0, 1'b0, 32'h0000_50FC, '0, 1'b0);

    // Reset again so the last-grant state starts from "icache last".
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_ic0 = '0;
    exp_dc0 = '0;
    chk_reset_state();

    // Tie: both requests held, dcache re-requests right after each ready.
    mif.ic_req = 1'b1; mif.ic_addr = 32'h0000_4004;
    for (int w = 0; w < 4; w++) begin
      bit g;
`ifdef ROUND_ROBIN_EN
      g = (w % 2 == 0);
`else
      g = 1'b1;
`endif
      mif.dc_req = 1'b1; mif.dc_we = 1'b0;
      mif.dc_addr  = 32'h0000_3005 + 32'(w * 16);
      mif.dc_wdata = {4{32'hC0DE_0000 + 32'(w)}};
      expect_acc(g, 1'b0, g ? mif.dc_addr : mif.ic_addr, g ? mif.dc_wdata : '0, cyc + 1, 1'b1);
      repeat (LAT + 3) tick();
    end
    mif.ic_req = 1'b0;
    mif.dc_req = 1'b0;
    tick();

    // Reset during WAIT cycle 3 aborts the access; the held request is then re-issued.
    mif.dc_req = 1'b1; mif.dc_we = 1'b0; mif.dc_addr = 32'h0000_6010;
    mif.dc_wdata = {4{32'h0F0F_0F0F}};
    expect_acc(1'b1, 1'b0, 32'h0000_6010, {4{32'h0F0F_0F0F}}, cyc + 1, 1'b0);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_ic0 = '0;
    exp_dc0 = '0;
    chk("abort_busy",     mif.busy,     1'b0);
    chk("abort_mem_en",   mif.mem_en,   1'b0);
    chk("abort_dc_ready", mif.dc_ready, 1'b0);
    chk("abort_dc_rdata", mif.dc_rdata, '0);
    run_acc(1'b1, 1'b0, 32'h0000_6010, {4{32'h0F0F_0F0F}}, 1'b0);

    // MEM_LATENCY=1: single dcache read, ready two cycles after the command.
    begin
      exp_t c;
      exp_t r;
      mif1.dc_req = 1'b1; mif1.dc_we = 1'b0; mif1.dc_addr = 32'h0000_9018;
      mif1.dc_wdata = {4{32'h3C3C_A5A5}};
      c.kind = 0; c.cyc = cyc + 1; c.addr = 32'h0000_9010; c.we = 1'b0;
      c.wdata = {4{32'h3C3C_A5A5}}; c.chk_wd = 1'b1; c.rdata = '0; c.gdc = 1'b1;
      q1.push_back(c);
      r = c; r.kind = 2; r.cyc = c.cyc + 2; r.rdata = line_of(32'h0000_9010);
      q1.push_back(r);
      repeat (LAT1 + 3) tick();
      mif1.dc_req = 1'b0;
    end

    repeat (4) tick();
    chk("q0_leftover", 128'(q0.size()), 128'd0);
    chk("q1_leftover", 128'(q1.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
